uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- UART transmitter that consumes the 9600-baud toggle clock produced by the baud divider (`baud_clk`) and serialises bytes onto `txd`.
- Contains a small write FIFO with a valid/ready handshake, so upstream logic can queue several bytes without waiting on the line.
- Runs entirely in the 100 MHz `clk` domain; `baud_clk` is treated as a data-rate enable, never as a clock.

Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first; legal range 5..9.
- FIFO_DEPTH, 4: FIFO entries; power of two, at least 2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- baud_clk  in  1  toggle output of the baud divider; each level change marks one bit period.
- tx_data  in  DATA_BITS  byte to queue.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a word this cycle.
- txd  out  1  serial line, idle high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued words.

Behaviour:
- Clocking and reset: single clock domain, synchronous active-high reset. All state updates on posedge `clk`.
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, FSM in IDLE, `baud_prev`=0, FIFO pointers 0.
- Reset mid-frame: the line returns high on the next edge, the current frame is aborted and the FIFO is flushed.
- Bit tick: `tick` = (`baud_clk` != `baud_prev`), where `baud_prev` is `baud_clk` registered once.
  - Since the divider toggles every 10417 clk cycles, one tick occurs per 9600-baud bit.
  - `txd` changes only on cycles where `tick`=1.
- FIFO:
  - Push when `tx_valid` && `tx_ready`; `tx_ready` = (`fifo_count` < FIFO_DEPTH).
  - Pop happens only from the FSM, only when `fifo_count` != 0 (registered value). No bypass: a word pushed in cycle N is poppable from cycle N+1.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - When full, `tx_ready`=0; a pop frees a slot, so `tx_ready`=1 the following cycle.
  - Pointers wrap modulo FIFO_DEPTH. `tx_valid` while full is ignored: no push, no error.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur on `tick`.
  - IDLE: if FIFO non-empty, pop into shift register, `txd`<=0, go to START. Otherwise `txd` stays 1.
  - START: `txd`<=shift[0], bit_idx<=0, go to DATA.
  - DATA:
    - If bit_idx==DATA_BITS-1: go to PARITY with `txd`<=parity if PARITY_EN, else go to STOP with `txd`<=1 and stop_cnt<=0.
    - Otherwise shift right, `txd`<=next bit, bit_idx+1.
  - PARITY: `txd`<=1, stop_cnt<=0, go to STOP.
    - Parity is the XOR of the data bits, inverted when PARITY_ODD=1. It is computed from the word captured at pop.
  - STOP:
    - If stop_cnt==STOP_BITS-1 and FIFO non-empty: pop, `txd`<=0, go to START (back-to-back frames, no idle gap).
    - If stop_cnt==STOP_BITS-1 and FIFO empty: go to IDLE with `txd`=1.
    - Otherwise stop_cnt+1.
- Frame length: 1+DATA_BITS+PARITY_EN+STOP_BITS ticks. The first start bit begins on the first tick after the word is visible in the FIFO.
- `busy` = (state != IDLE) || (`fifo_count` != 0); registered or combinational, but 0 out of reset.
- Corner case: a `tick` coincident with the push into an empty FIFO does not start a frame. The frame starts on the next tick.

Test Plan:
- Reset, then hold baud_clk at 0 -> `txd`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0 indefinitely.
- Push 0x55, toggle baud_clk every 16 clk -> txd sequence per tick 0,1,0,1,0,1,0,1,0,1 then idle 1; `busy` drops after the stop bit.
- PARITY_EN=1, push 0x55:
  - PARITY_ODD=0 -> parity bit 0.
  - PARITY_ODD=1 -> parity bit 1.
  - Push 0x07 with PARITY_ODD=0 -> parity bit 1.
- Push 5 words 0x01..0x05 back-to-back at full rate, FIFO_DEPTH=4:
  - The 5th word is held until `tx_ready` reasserts after the first pop; `fifo_count` peaks at 4.
  - All five frames are emitted with no idle tick between stop and start.
- STOP_BITS=2, push 0xA3 -> start 0, data 1,1,0,0,0,1,0,1, then two ticks of 1.
- Assert rst during the DATA state of a frame with 2 words queued -> next cycle `txd`=1 and `fifo_count`=0; no further frames after reset is released.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO. baud_clk is a toggle from the baud
// divider; each level change is one bit period, detected as an enable in clk.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_clk,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  state_t               state_q, state_d;
  logic                 baud_prev_q, baud_prev_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 tick;
  logic                 push;
  logic                 pop;
  logic                 start_frame;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (count_q < CW'(FIFO_DEPTH));
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign txd        = txd_q;
  assign fifo_count = count_q;

  always_comb begin
    tick        = (baud_clk != baud_prev_q);
    push        = tx_valid && tx_ready;
    head        = mem_q[rd_ptr_q];
    pop         = 1'b0;
    start_frame = 1'b0;
    baud_prev_d = baud_clk;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    txd_d       = txd_q;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) start_frame = 1'b1;
          else               txd_d       = 1'b1;
        end
        START: begin
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_idx_q == IW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              txd_d   = parity_q;
              state_d = PARITY;
            end else begin
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        PARITY: begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit so queued frames have no idle gap.
            if (count_q != '0) begin
              start_frame = 1'b1;
            end else begin
              txd_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    if (start_frame) begin
      pop      = 1'b1;
      shift_d  = head;
      parity_d = (^head) ^ 1'(PARITY_ODD);
      txd_d    = 1'b0;
      state_d  = START;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_prev_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      parity_q    <= 1'b0;
      txd_q       <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      baud_prev_q <= baud_prev_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      parity_q    <= parity_d;
      txd_q       <= txd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 8N2) driven one at a
// time, line output compared per bit period against an expected frame stream.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_clk;
  logic [7:0] tx_data;
  logic       tx_valid   [4];
  logic       tx_ready   [4];
  logic       txd        [4];
  logic       busy       [4];
  logic [2:0] fifo_count [4];

  int n_tests = 0;
  int n_fail  = 0;
  int peak;

  int cfg_pen  [4] = '{0, 1, 1, 0};
  int cfg_odd  [4] = '{0, 0, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};

  bit         exp_q[$];
  logic [7:0] burst_words [5];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]), .fifo_count(fifo_count[0]));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]), .fifo_count(fifo_count[1]));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]), .fifo_count(fifo_count[2]));
  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .txd(txd[3]), .busy(busy[3]), .fifo_count(fifo_count[3]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop ones.
  function automatic void add_frame(input int k, input logic [7:0] w);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (cfg_pen[k] != 0) exp_q.push_back(((ones % 2) == 1) != (cfg_odd[k] != 0));
    for (int s = 0; s < cfg_stop[k]; s++) exp_q.push_back(1'b1);
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) tx_valid[k] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted, valid still high.
  task automatic applyStimulus(input int k, input logic [7:0] w);
    int waited = 0;
    tx_data     = w;
    tx_valid[k] = 1'b1;
    while (!tx_ready[k] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput($sformatf("push_wait_dut%0d", k), 32'(waited < 400), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_tick(input int k, input logic exp_txd, input logic exp_busy, input string tag);
    @(negedge clk);
    baud_clk = ~baud_clk;
    @(posedge clk);
    #1;
    checkOutput({tag, "_txd"}, 32'(txd[k]), 32'(exp_txd));
    checkOutput({tag, "_busy"}, 32'(busy[k]), 32'(exp_busy));
    repeat (14) @(posedge clk);
    #1;
    checkOutput({tag, "_hold"}, 32'(txd[k]), 32'(exp_txd));
  endtask

  task automatic run_stream(input int k, input int extra, input string tag);
    int len = exp_q.size();
    for (int i = 0; i < len + extra; i++)
      do_tick(k, (i < len) ? exp_q[i] : 1'b1, i < len, $sformatf("%s_d%0d_t%0d", tag, k, i));
    exp_q.delete();
  endtask

  task automatic single_word(input int k, input logic [7:0] w, input string tag);
    applyReset();
    @(negedge clk);
    applyStimulus(k, w);
    tx_valid[k] = 1'b0;
    checkOutput({tag, "_count"}, 32'(fifo_count[k]), 32'd1);
    checkOutput({tag, "_busy_q"}, 32'(busy[k]), 32'd1);
    add_frame(k, w);
    run_stream(k, 2, tag);
  endtask

  task automatic run_burst(input int k, input string tag);
    applyReset();
    for (int i = 0; i < 5; i++) add_frame(k, burst_words[i]);
    @(negedge clk);
    fork
      begin
        peak = 0;
        for (int i = 0; i < 5; i++) begin
          if (i == 4) checkOutput({tag, "_full_ready"}, 32'(tx_ready[k]), 32'd0);
          applyStimulus(k, burst_words[i]);
          if (int'(fifo_count[k]) > peak) peak = int'(fifo_count[k]);
        end
        tx_valid[k] = 1'b0;
        checkOutput({tag, "_peak"}, 32'(peak), 32'd4);
      end
      begin
        repeat (8) @(negedge clk);
        run_stream(k, 3, tag);
      end
    join
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int n;
    logic [7:0] w;
    rst      = 1'b1;
    baud_clk = 1'b0;
    tx_data  = 8'h00;
    for (int i = 0; i < 4; i++) tx_valid[i] = 1'b0;

    // Idle after reset with baud_clk held low.
    applyReset();
    for (int j = 0; j < 4; j++) begin
      repeat (10) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checkOutput($sformatf("idle_txd_d%0d", d), 32'(txd[d]), 32'd1);
        checkOutput($sformatf("idle_ready_d%0d", d), 32'(tx_ready[d]), 32'd1);
        checkOutput($sformatf("idle_busy_d%0d", d), 32'(busy[d]), 32'd0);
        checkOutput($sformatf("idle_count_d%0d", d), 32'(fifo_count[d]), 32'd0);
      end
    end

    // Directed frames: 0x55 on every configuration, 0x07 even parity, 0xA3 two stop bits.
    for (int d = 0; d < 4; d++) single_word(d, 8'h55, "w55");
    single_word(1, 8'h07, "w07");
    single_word(3, 8'hA3, "wA3");

    // Push coincident with a tick into an empty FIFO must not start a frame.
    applyReset();
    @(negedge clk);
    tx_data     = 8'h9C;
    tx_valid[0] = 1'b1;
    baud_clk    = ~baud_clk;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    checkOutput("corner_count", 32'(fifo_count[0]), 32'd1);
    checkOutput("corner_txd", 32'(txd[0]), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("corner_txd_late", 32'(txd[0]), 32'd1);
    add_frame(0, 8'h9C);
    run_stream(0, 2, "corner");

    // Five words at full rate into a depth-4 FIFO.
    for (int i = 0; i < 5; i++) burst_words[i] = 8'(i + 1);
    run_burst(0, "burst_seq");
    for (int i = 0; i < 5; i++) burst_words[i] = 8'($urandom);
    run_burst(1, "burst_rnd_e");
    for (int i = 0; i < 5; i++) burst_words[i] = 8'($urandom);
    run_burst(3, "burst_rnd_2s");

    // Reset in the middle of the data bits with two words still queued.
    applyReset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom);
      if (i == 0) add_frame(0, w);
      applyStimulus(0, w);
    end
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) do_tick(0, exp_q[i], 1'b1, $sformatf("pre_rst_t%0d", i));
    exp_q.delete();
    checkOutput("pre_rst_count", 32'(fifo_count[0]), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_txd", 32'(txd[0]), 32'd1);
    checkOutput("rst_count", 32'(fifo_count[0]), 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_stream(0, 12, "post_rst");

    // Randomized word counts, data and configuration.
    for (int r = 0; r < 8; r++) begin
      k = int'($urandom_range(3, 0));
      n = int'($urandom_range(4, 1));
      applyReset();
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        w = 8'($urandom);
        add_frame(k, w);
        applyStimulus(k, w);
      end
      tx_valid[k] = 1'b0;
      checkOutput($sformatf("rnd%0d_count", r), 32'(fifo_count[k]), 32'(n));
      run_stream(k, 2, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
